// File: rtl/ring_param.sv
// ring_param: peak-to-peak (max-min) measurement of ADC samples over windows
//   clk_sys     in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   adc_data    in   16-bit unsigned sample
//   adc_vld     in   sample strobe
//   cfg_en      in   measurement enable; low aborts an open window
//   cfg_win_len in   samples per window, 0 treated as 1, latched at window start
//   ph_ring     out  peak-to-peak of last completed window (held between strobes)
//   ph_vld      out  one-cycle strobe, ph_ring updated this cycle
//   stu_busy    out  high while in ACQ
// Optional: define RING_AVG4_EN to report the mean of the last four window results.
module ring_param (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [15:0] adc_data,
    input  logic        adc_vld,
    input  logic        cfg_en,
    input  logic [15:0] cfg_win_len,
    output logic [15:0] ph_ring,
    output logic        ph_vld,
    output logic        stu_busy
);
    typedef enum logic {IDLE, ACQ} state_t;
    state_t      state_q, state_d;
    logic [15:0] len_q, len_d, cnt_q, cnt_d, max_q, max_d, min_q, min_d, ring_q, ring_d;
    logic        vld_q, vld_d;
    logic        smp, first, done;
    logic [15:0] len_e, cnt_n, mx, mn, pp;
`ifdef RING_AVG4_EN
    // three previous results; together with the current one they form the 4-deep history
    logic [2:0][15:0] hist_q, hist_d;
    logic [17:0]      sum;
`endif
    always_comb begin
        smp   = cfg_en && adc_vld;
        // cnt_q==0 in ACQ means the previous window just closed: next sample opens a new one
        first = (state_q == IDLE) || (cnt_q == 16'd0);
        len_e = first ? ((cfg_win_len == 16'd0) ? 16'd1 : cfg_win_len) : len_q;
        cnt_n = first ? 16'd1 : cnt_q + 16'd1;
        mx    = (first || adc_data > max_q) ? adc_data : max_q;
        mn    = (first || adc_data < min_q) ? adc_data : min_q;
        pp    = mx - mn;
        done  = smp && (cnt_n == len_e);
        state_d = !cfg_en ? IDLE : smp ? ACQ : state_q;
        len_d   = smp ? len_e : len_q;
        cnt_d   = (!cfg_en || done) ? 16'd0 : smp ? cnt_n : cnt_q;
        max_d   = (!cfg_en || done) ? 16'd0 : smp ? mx : max_q;
        min_d   = (!cfg_en || done) ? 16'd0 : smp ? mn : min_q;
        vld_d   = done;
`ifdef RING_AVG4_EN
        hist_d  = done ? {hist_q[1:0], pp} : hist_q;
        sum     = {2'b0, pp} + {2'b0, hist_q[0]} + {2'b0, hist_q[1]} + {2'b0, hist_q[2]};
        ring_d  = done ? sum[17:2] : ring_q;
`else
        ring_d  = done ? pp : ring_q;
`endif
    end
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            max_q   <= '0;
            min_q   <= '0;
            ring_q  <= '0;
            vld_q   <= 1'b0;
`ifdef RING_AVG4_EN
            hist_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            min_q   <= min_d;
            ring_q  <= ring_d;
            vld_q   <= vld_d;
`ifdef RING_AVG4_EN
            hist_q  <= hist_d;
`endif
        end
    end
    assign ph_ring  = ring_q;
    assign ph_vld   = vld_q;
    assign stu_busy = (state_q == ACQ);
endmodule
